// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared types and constants for the SPI receive framer
package spi_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      CLOSE  = 2'd2
   } framer_state_t;

   localparam int         SPI_BYTE_W           = 8;
   localparam int         SPI_RX_DEPTH_DEFAULT = 16;
   localparam logic [7:0] LEN_MAX              = 8'hFF;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == LEN_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/spi_rx_framer_if.sv
// rtl/spi_rx_framer_if.sv - byte-in / FIFO-and-status-out bundle of the SPI receive framer
interface spi_rx_framer_if #(parameter int DEPTH = 16);

   localparam int LW = $clog2(DEPTH) + 1;

   logic                                 cs_active;
   logic                                 rx_valid;
   logic [spi_rx_pkg::SPI_BYTE_W-1:0]    rx_byte;
   logic                                 rd_pop;
   logic                                 clr_status;
   logic [spi_rx_pkg::SPI_BYTE_W-1:0]    rd_data;
   logic [LW-1:0]                        level;
   logic                                 empty;
   logic                                 full;
   logic                                 overflow;
   logic                                 frame_done;
   logic [7:0]                           frame_cnt;
   logic [7:0]                           last_len;
   logic                                 csum_err;

   modport master (
      output cs_active, rx_valid, rx_byte, rd_pop, clr_status,
      input  rd_data, level, empty, full, overflow, frame_done, frame_cnt, last_len, csum_err
   );

   modport slave (
      input  cs_active, rx_valid, rx_byte, rd_pop, clr_status,
      output rd_data, level, empty, full, overflow, frame_done, frame_cnt, last_len, csum_err
   );

endinterface

// File: rtl/spi_rx_framer_sync_fifo.sv
// rtl/spi_rx_framer_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int DW    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     full
);

   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_LVL = (AW + 1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   // A push into a full FIFO only lands when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop && (level_q != '0);
      do_push  = push && ((level_q != FULL_LVL) || do_pop);
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
      level_d  = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign empty = (level_q == '0);
   assign full  = (level_q == FULL_LVL);
   assign level = level_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_rx_framer.sv
// rtl/spi_rx_framer.sv - CS-delimited byte framer with FIFO; SPI_RX_CHECKSUM_EN adds XOR frame check
module spi_rx_framer
   import spi_rx_pkg::*;
#(
   parameter int DEPTH = SPI_RX_DEPTH_DEFAULT,
   parameter int DW    = SPI_BYTE_W
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_rx_framer_if.slave  bus
);

   if (DW != SPI_BYTE_W) begin : g_bad_dw
      $error("spi_rx_framer: DW must be 8");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("spi_rx_framer: DEPTH must be a power of 2 and at least 2");
   end

   framer_state_t state_q, state_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic [7:0]    last_len_q, last_len_d;
   logic          overflow_q, overflow_d;
   logic          frame_done_q, frame_done_d;
   logic          push, closing, fifo_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.cs_active)  state_d = ACTIVE;
         ACTIVE:  if (!bus.cs_active) state_d = CLOSE;
         CLOSE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A byte arriving on the cycle CS drops still belongs to the closing frame.
   always_comb begin
      push         = (state_q == ACTIVE) && bus.rx_valid;
      closing      = (state_q == ACTIVE) && !bus.cs_active;
      len_d        = (state_q == IDLE) ? 8'd0 : (push ? sat_inc(len_q) : len_q);
      frame_done_d = closing;
      last_len_d   = closing ? len_d : last_len_q;
      frame_cnt_d  = closing ? frame_cnt_q + 8'd1 : frame_cnt_q;
      overflow_d   = (push && fifo_full && !bus.rd_pop) || (overflow_q && !bus.clr_status);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q        <= '0;
         frame_cnt_q  <= '0;
         last_len_q   <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         len_q        <= len_d;
         frame_cnt_q  <= frame_cnt_d;
         last_len_q   <= last_len_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef SPI_RX_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   logic       csum_err_q, csum_err_d;

   // A correct frame carries a trailer that brings the running XOR back to zero.
   always_comb begin
      csum_d     = (state_q == IDLE) ? 8'd0 : (push ? (csum_q ^ bus.rx_byte) : csum_q);
      csum_err_d = (closing && (len_d != 8'd0) && (csum_d != 8'd0))
                   || (csum_err_q && !bus.clr_status);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q     <= '0;
         csum_err_q <= 1'b0;
      end else begin
         csum_q     <= csum_d;
         csum_err_q <= csum_err_d;
      end
   end

   assign bus.csum_err = csum_err_q;
`else
   assign bus.csum_err = 1'b0;
`endif

   sync_fifo #(
      .DEPTH (DEPTH),
      .DW    (SPI_BYTE_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (bus.rd_pop),
      .wdata (bus.rx_byte),
      .rdata (bus.rd_data),
      .level (bus.level),
      .empty (bus.empty),
      .full  (fifo_full)
   );

   assign bus.full       = fifo_full;
   assign bus.overflow   = overflow_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_cnt  = frame_cnt_q;
   assign bus.last_len   = last_len_q;

endmodule

// File: tb/tb_spi_rx_framer.sv
// tb/tb_spi_rx_framer.sv - self-checking bench for spi_rx_framer
module tb_spi_rx_framer;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_rx_framer_if #(.DEPTH(DEPTH)) bus();

   spi_rx_framer #(.DEPTH(DEPTH), .DW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: FIFO contents as a queue, frames tracked from the stimulus.
   logic [7:0] q[$];
   logic [7:0] fb[$];
   int         ml, elast, efc;
   logic [7:0] mx;
   bit         eov, ecs, edone;

   typedef struct {
      bit         cs, v, pop;
      logic [7:0] b;
      int         lvl;
      logic [7:0] rd;
      bit         done;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic bit rp(input int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   task automatic chk_all();
      chk("level", 32'(bus.level), q.size());
      chk("rd_data", 32'(bus.rd_data), (q.size() != 0) ? int'(q[0]) : 0);
      chk("empty", 32'(bus.empty), int'(q.size() == 0));
      chk("full", 32'(bus.full), int'(q.size() == DEPTH));
      chk("overflow", 32'(bus.overflow), int'(eov));
      chk("frame_done", 32'(bus.frame_done), int'(edone));
      chk("last_len", 32'(bus.last_len), elast);
      chk("frame_cnt", 32'(bus.frame_cnt), efc);
      chk("csum_err", 32'(bus.csum_err), int'(ecs));
   endtask

   // acc: stimulus places this byte inside a frame; close: this cycle samples CS low in a frame.
   task automatic cyc(input bit cs, input bit v, input logic [7:0] b, input bit pop,
                      input bit clr, input bit acc, input bit close);
      int pre;
      bit dp, dpu, cset;
      bus.cs_active  = cs;
      bus.rx_valid   = v;
      bus.rx_byte    = b;
      bus.rd_pop     = pop;
      bus.clr_status = clr;
      @(posedge clk); #1;
      bus.rx_valid   = 1'b0;
      bus.rd_pop     = 1'b0;
      bus.clr_status = 1'b0;
      pre = q.size();
      dp  = pop && (pre > 0);
      dpu = acc && ((pre < DEPTH) || dp);
      if (dp)  void'(q.pop_front());
      if (dpu) q.push_back(b);
      if (acc) begin
         ml = (ml < 255) ? ml + 1 : 255;
         mx = mx ^ b;
      end
      eov   = (acc && !dpu) ? 1'b1 : (clr ? 1'b0 : eov);
      edone = close;
      cset  = 1'b0;
      if (close) begin
         elast = ml;
         efc   = (efc + 1) % 256;
`ifdef SPI_RX_CHECKSUM_EN
         cset  = (ml != 0) && (mx != 8'h00);
`endif
         ml = 0;
         mx = 8'h00;
      end
      ecs = cset ? 1'b1 : (clr ? 1'b0 : ecs);
      chk_all();
   endtask

   task automatic frame_q(input bit pop);
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      foreach (fb[i]) cyc(1, 1, fb[i], pop, 0, 1, 0);
      cyc(0, 0, 8'h00, pop, 0, 0, 1);
      cyc(0, 0, 8'h00, 0, 0, 0, 0);
   endtask

   task automatic rand_frame(input int n, input int pop_pct);
      bit coin;
      coin = 1'($urandom_range(0, 1));
      cyc(1, 0, 8'h00, rp(pop_pct), 0, 0, 0);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) cyc(1, 0, 8'h00, rp(pop_pct), 0, 0, 0);
         cyc(1, 1, 8'($urandom), rp(pop_pct), rp(5), 1, 0);
      end
      cyc(0, coin, 8'($urandom), rp(pop_pct), 0, coin, 1);
      cyc(0, 1'($urandom_range(0, 1)), 8'($urandom), rp(pop_pct), 0, 0, 0);
      cyc(0, 0, 8'h00, rp(pop_pct), 0, 0, 0);
   endtask

   task automatic model_reset();
      q.delete();
      ml = 0; mx = 8'h00; elast = 0; efc = 0;
      eov = 1'b0; ecs = 1'b0; edone = 1'b0;
   endtask

   task automatic chk_reset();
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      chk("rst_level", 32'(bus.level), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      chk("rst_frame_done", 32'(bus.frame_done), 0);
      chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
      chk("rst_last_len", 32'(bus.last_len), 0);
      chk("rst_csum_err", 32'(bus.csum_err), 0);
   endtask

   initial begin
      bus.cs_active = 0; bus.rx_valid = 0; bus.rx_byte = 0;
      bus.rd_pop = 0; bus.clr_status = 0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      rst_n = 1'b1;

      // 3-byte frame, last byte on the CS-low sample, an IDLE byte, then drain.
      tbl[0] = '{1, 0, 0, 8'h00, 0, 8'h00, 0};
      tbl[1] = '{1, 1, 0, 8'h11, 1, 8'h11, 0};
      tbl[2] = '{1, 1, 0, 8'h22, 2, 8'h11, 0};
      tbl[3] = '{0, 1, 0, 8'h33, 3, 8'h11, 1};
      tbl[4] = '{0, 0, 0, 8'h00, 3, 8'h11, 0};
      tbl[5] = '{0, 1, 0, 8'h44, 3, 8'h11, 0};
      tbl[6] = '{0, 0, 1, 8'h00, 2, 8'h22, 0};
      tbl[7] = '{0, 0, 1, 8'h00, 1, 8'h33, 0};
      tbl[8] = '{0, 0, 1, 8'h00, 0, 8'h00, 0};
      tbl[9] = '{0, 0, 1, 8'h00, 0, 8'h00, 0};
      for (int i = 0; i < 10; i++) begin
         bus.cs_active = tbl[i].cs;
         bus.rx_valid  = tbl[i].v;
         bus.rx_byte   = tbl[i].b;
         bus.rd_pop    = tbl[i].pop;
         @(posedge clk); #1;
         bus.rx_valid = 1'b0;
         bus.rd_pop   = 1'b0;
         chk($sformatf("tbl%0d_level", i), 32'(bus.level), tbl[i].lvl);
         chk($sformatf("tbl%0d_rd_data", i), 32'(bus.rd_data), int'(tbl[i].rd));
         chk($sformatf("tbl%0d_frame_done", i), 32'(bus.frame_done), int'(tbl[i].done));
         chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), int'(tbl[i].lvl == 0));
      end
      chk("tbl_last_len", 32'(bus.last_len), 3);
      chk("tbl_frame_cnt", 32'(bus.frame_cnt), 1);
      q.delete(); elast = 3; efc = 1; ml = 0; mx = 8'h00;

      // 20-byte frame into a 16-deep FIFO, then clear the sticky flag.
      fb.delete();
      for (int i = 0; i < 20; i++) fb.push_back(8'(8'h80 + i));
      frame_q(0);
      chk("ovf_last_len", 32'(bus.last_len), 20);
      chk("ovf_flag", 32'(bus.overflow), 1);
      cyc(0, 0, 8'h00, 0, 1, 0, 0);

      // Push and pop together while full.
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      cyc(1, 1, 8'hC0, 1, 0, 1, 0);
      cyc(1, 1, 8'hC1, 1, 0, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 0, 1);
      cyc(0, 0, 8'h00, 0, 0, 0, 0);
      repeat (DEPTH + 1) cyc(0, 0, 8'h00, 1, 0, 0, 0);

      // Length saturation, then 256 empty frames to wrap the frame counter.
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) cyc(1, 1, 8'(i), 0, 0, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 0, 1);
      chk("sat_last_len", 32'(bus.last_len), 255);
      cyc(0, 0, 8'h00, 0, 1, 0, 0);
      repeat (DEPTH) cyc(0, 0, 8'h00, 1, 0, 0, 0);
      repeat (256) begin
         cyc(1, 0, 8'h00, 0, 0, 0, 0);
         cyc(0, 0, 8'h00, 0, 0, 0, 1);
         cyc(0, 0, 8'h00, 0, 0, 0, 0);
      end
      chk("wrap_last_len", 32'(bus.last_len), 0);

      // Checksum frames: one balanced, two not.
      cyc(0, 0, 8'h00, 0, 1, 0, 0);
      fb = {8'hA5, 8'h5A, 8'hFF};
      frame_q(1);
      fb = {8'hA5, 8'h5A, 8'hFF, 8'hFF};
      frame_q(1);
      cyc(0, 0, 8'h00, 0, 1, 0, 0);
      fb = {8'h01, 8'h02};
      frame_q(1);
      cyc(0, 0, 8'h00, 1, 1, 0, 0);

      // Randomized frames against the model.
      for (int f = 0; f < 40; f++) rand_frame($urandom_range(0, 22), $urandom_range(0, 70));
      repeat (DEPTH) cyc(0, 0, 8'h00, 1, 1, 0, 0);

      // Reset mid-frame with CS still high: the rest becomes a new frame.
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      cyc(1, 1, 8'h61, 0, 0, 1, 0);
      cyc(1, 1, 8'h62, 0, 0, 1, 0);
      rst_n = 1'b0;
      #2;
      chk_reset();
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      cyc(1, 1, 8'h70, 0, 0, 1, 0);
      cyc(1, 1, 8'h71, 0, 0, 1, 0);
      cyc(0, 0, 8'h00, 0, 0, 0, 1);
      chk("rst_frame_len", 32'(bus.last_len), 2);
      chk("rst_frame_cnt_after", 32'(bus.frame_cnt), 1);
      cyc(0, 0, 8'h00, 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
